// File: rtl/sysp_icb_arbiter_pkg.sv
// Shared types and defaults for the sysp ICB two-master arbiter.
// Optional read-response timeout is enabled with SYSP_ARB_TIMEOUT_EN.
package sysp_icb_arbiter_pkg;

    localparam int unsigned SyspAwDef      = 32;
    localparam int unsigned SyspDwDef      = 32;
    localparam int unsigned SyspTimeoutDef = 64;
    localparam int unsigned SyspCntW       = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitRsp = 2'd1,
        StErr     = 2'd2
    } arb_state_e;

    typedef enum logic {
        MstM0 = 1'b0,
        MstM1 = 1'b1
    } mst_e;

    function automatic mst_e other_mst(input mst_e m);
        return (m == MstM0) ? MstM1 : MstM0;
    endfunction

endpackage

// File: rtl/sysp_icb_arbiter_rr_pick.sv
// Two-way round-robin picker: pure combinational, priority register lives in the parent.
module sysp_icb_arbiter_rr_pick
    import sysp_icb_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_e       prio_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (prio_i == MstM0) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sysp_icb_arbiter.sv
// Round-robin arbiter sharing the sysp ICB slave between m0 (LSU) and m1 (DMA/debug).
// Define SYSP_ARB_TIMEOUT_EN to add the read-response timeout and error-response state.
module sysp_icb_arbiter
    import sysp_icb_arbiter_pkg::*;
#(
    parameter int unsigned AW          = SyspAwDef,
    parameter int unsigned DW          = SyspDwDef,
    parameter int unsigned TIMEOUT_CYC = SyspTimeoutDef
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_icb_cmd_valid_i,
    output logic          m0_icb_cmd_ready_o,
    input  logic [AW-1:0] m0_icb_cmd_addr_i,
    input  logic          m0_icb_cmd_read_i,
    input  logic [DW-1:0] m0_icb_cmd_wdata_i,
    input  logic [3:0]    m0_icb_cmd_wmask_i,
    output logic          m0_icb_rsp_valid_o,
    input  logic          m0_icb_rsp_ready_i,
    output logic          m0_icb_rsp_err_o,
    output logic [DW-1:0] m0_icb_rsp_rdata_o,

    input  logic          m1_icb_cmd_valid_i,
    output logic          m1_icb_cmd_ready_o,
    input  logic [AW-1:0] m1_icb_cmd_addr_i,
    input  logic          m1_icb_cmd_read_i,
    input  logic [DW-1:0] m1_icb_cmd_wdata_i,
    input  logic [3:0]    m1_icb_cmd_wmask_i,
    output logic          m1_icb_rsp_valid_o,
    input  logic          m1_icb_rsp_ready_i,
    output logic          m1_icb_rsp_err_o,
    output logic [DW-1:0] m1_icb_rsp_rdata_o,

    output logic          s_icb_cmd_valid_o,
    input  logic          s_icb_cmd_ready_i,
    output logic [AW-1:0] s_icb_cmd_addr_o,
    output logic          s_icb_cmd_read_o,
    output logic [DW-1:0] s_icb_cmd_wdata_o,
    output logic [3:0]    s_icb_cmd_wmask_o,
    input  logic          s_icb_rsp_valid_i,
    output logic          s_icb_rsp_ready_o,
    input  logic          s_icb_rsp_err_i,
    input  logic [DW-1:0] s_icb_rsp_rdata_i
);

    arb_state_e state_q;
    mst_e       prio_q;
    mst_e       owner_q;

    logic [1:0] req;
    logic [1:0] grant;
    mst_e       gnt_sel;
    logic       in_idle;
    logic       in_wait;
    logic       in_err;
    logic       cmd_accept;
    logic       owner_rsp_ready;

    assign req     = {m1_icb_cmd_valid_i, m0_icb_cmd_valid_i};
    assign gnt_sel = grant[1] ? MstM1 : MstM0;

    // Outputs are forced quiet while reset is held, whatever the registered state.
    assign in_idle = !rst_i && (state_q == StIdle);
    assign in_wait = !rst_i && (state_q == StWaitRsp);
    assign in_err  = !rst_i && (state_q == StErr);

    assign owner_rsp_ready = (owner_q == MstM1) ? m1_icb_rsp_ready_i : m0_icb_rsp_ready_i;

    sysp_icb_arbiter_rr_pick u_rr_pick (
        .req_i   (req),
        .prio_i  (prio_q),
        .grant_o (grant)
    );

    // Command mux toward the slave.
    always_comb begin
        s_icb_cmd_valid_o  = in_idle && (|req);
        s_icb_cmd_addr_o   = (gnt_sel == MstM1) ? m1_icb_cmd_addr_i  : m0_icb_cmd_addr_i;
        s_icb_cmd_read_o   = (gnt_sel == MstM1) ? m1_icb_cmd_read_i  : m0_icb_cmd_read_i;
        s_icb_cmd_wdata_o  = (gnt_sel == MstM1) ? m1_icb_cmd_wdata_i : m0_icb_cmd_wdata_i;
        s_icb_cmd_wmask_o  = (gnt_sel == MstM1) ? m1_icb_cmd_wmask_i : m0_icb_cmd_wmask_i;
        m0_icb_cmd_ready_o = in_idle && grant[0] && s_icb_cmd_ready_i;
        m1_icb_cmd_ready_o = in_idle && grant[1] && s_icb_cmd_ready_i;
    end

    assign cmd_accept = s_icb_cmd_valid_o && s_icb_cmd_ready_i;

    // Response demux: only the owner of the outstanding read ever sees rsp_valid.
    always_comb begin
        m0_icb_rsp_valid_o = 1'b0;
        m0_icb_rsp_err_o   = 1'b0;
        m0_icb_rsp_rdata_o = '0;
        m1_icb_rsp_valid_o = 1'b0;
        m1_icb_rsp_err_o   = 1'b0;
        m1_icb_rsp_rdata_o = '0;
        s_icb_rsp_ready_o  = 1'b0;
        if (in_idle) begin
            s_icb_rsp_ready_o = 1'b1;
        end else if (in_wait) begin
            s_icb_rsp_ready_o = owner_rsp_ready;
            if (owner_q == MstM1) begin
                m1_icb_rsp_valid_o = s_icb_rsp_valid_i;
                m1_icb_rsp_err_o   = s_icb_rsp_valid_i && s_icb_rsp_err_i;
                m1_icb_rsp_rdata_o = s_icb_rsp_valid_i ? s_icb_rsp_rdata_i : '0;
            end else begin
                m0_icb_rsp_valid_o = s_icb_rsp_valid_i;
                m0_icb_rsp_err_o   = s_icb_rsp_valid_i && s_icb_rsp_err_i;
                m0_icb_rsp_rdata_o = s_icb_rsp_valid_i ? s_icb_rsp_rdata_i : '0;
            end
        end else if (in_err) begin
            if (owner_q == MstM1) begin
                m1_icb_rsp_valid_o = 1'b1;
                m1_icb_rsp_err_o   = 1'b1;
            end else begin
                m0_icb_rsp_valid_o = 1'b1;
                m0_icb_rsp_err_o   = 1'b1;
            end
        end
    end

`ifdef SYSP_ARB_TIMEOUT_EN
    localparam logic [SyspCntW-1:0] TimeoutLast = SyspCntW'(TIMEOUT_CYC - 1);
    logic [SyspCntW-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            prio_q  <= MstM0;
            owner_q <= MstM0;
`ifdef SYSP_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_accept) begin
                        prio_q <= other_mst(gnt_sel);
                        if (s_icb_cmd_read_o) begin
                            owner_q <= gnt_sel;
                            state_q <= StWaitRsp;
`ifdef SYSP_ARB_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                StWaitRsp: begin
                    // A slave response arriving on the expiry cycle wins over the timeout.
                    if (s_icb_rsp_valid_i) begin
                        if (owner_rsp_ready) begin
                            state_q <= StIdle;
                        end
                    end
`ifdef SYSP_ARB_TIMEOUT_EN
                    else if (cnt_q == TimeoutLast) begin
                        state_q <= StErr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                StErr: begin
                    if (owner_rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sysp_icb_arbiter.sv
// Self-checking bench for sysp_icb_arbiter: directed scenarios then randomized traffic
// against a transaction-level model of the arbitration and response-routing rules.
module tb_sysp_icb_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          mv[2], mrd[2], mrr[2];
    logic [AW-1:0] ma[2];
    logic [DW-1:0] mwd[2];
    logic [3:0]    mwm[2];
    logic          mcr[2], mrv[2], mre[2];
    logic [DW-1:0] mrdat[2];

    logic          scv, scr, srd, srv, srr, sre;
    logic [AW-1:0] sa;
    logic [DW-1:0] swd, srdat;
    logic [3:0]    swm;

    sysp_icb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .m0_icb_cmd_valid_i (mv[0]),
        .m0_icb_cmd_ready_o (mcr[0]),
        .m0_icb_cmd_addr_i  (ma[0]),
        .m0_icb_cmd_read_i  (mrd[0]),
        .m0_icb_cmd_wdata_i (mwd[0]),
        .m0_icb_cmd_wmask_i (mwm[0]),
        .m0_icb_rsp_valid_o (mrv[0]),
        .m0_icb_rsp_ready_i (mrr[0]),
        .m0_icb_rsp_err_o   (mre[0]),
        .m0_icb_rsp_rdata_o (mrdat[0]),
        .m1_icb_cmd_valid_i (mv[1]),
        .m1_icb_cmd_ready_o (mcr[1]),
        .m1_icb_cmd_addr_i  (ma[1]),
        .m1_icb_cmd_read_i  (mrd[1]),
        .m1_icb_cmd_wdata_i (mwd[1]),
        .m1_icb_cmd_wmask_i (mwm[1]),
        .m1_icb_rsp_valid_o (mrv[1]),
        .m1_icb_rsp_ready_i (mrr[1]),
        .m1_icb_rsp_err_o   (mre[1]),
        .m1_icb_rsp_rdata_o (mrdat[1]),
        .s_icb_cmd_valid_o  (scv),
        .s_icb_cmd_ready_i  (scr),
        .s_icb_cmd_addr_o   (sa),
        .s_icb_cmd_read_o   (srd),
        .s_icb_cmd_wdata_o  (swd),
        .s_icb_cmd_wmask_o  (swm),
        .s_icb_rsp_valid_i  (srv),
        .s_icb_rsp_ready_o  (srr),
        .s_icb_rsp_err_i    (sre),
        .s_icb_rsp_rdata_i  (srdat)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: 0 = free, 1 = read outstanding, 2 = timed-out error response.
    int   mst      = 0;
    logic last_acc = 1'b1;
    logic owner    = 1'b0;
    int   wcnt     = 0;
    bit   ev_acc, ev_hs;
    logic ev_g;

    // Randomized slave state.
    bit   pend = 0;
    int   dly  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_now();
        bit   has_g;
        logic gi;
        logic o;
        #4;
        ev_acc = 0;
        ev_hs  = 0;
        has_g  = 0;
        gi     = 1'b0;
        if (rst) begin
            chk("rst_cmd", {scv, srr, mcr[0], mcr[1]}, 64'd0);
            chk("rst_rsp", {mrv[0], mrv[1], mre[0], mre[1]}, 64'd0);
            chk("rst_rdata", {mrdat[0], mrdat[1]}, 64'd0);
        end else if (mst == 0) begin
            if (mv[0] && mv[1]) begin has_g = 1; gi = ~last_acc; end
            else if (mv[0])     begin has_g = 1; gi = 1'b0; end
            else if (mv[1])     begin has_g = 1; gi = 1'b1; end
            chk("s_cmd_valid", scv, has_g);
            chk("m0_cmd_ready", mcr[0], has_g && !gi && scr);
            chk("m1_cmd_ready", mcr[1], has_g && gi && scr);
            if (has_g) begin
                chk("s_cmd_addr_wdata", {sa, swd}, {ma[gi], mwd[gi]});
                chk("s_cmd_read_wmask", {srd, swm}, {mrd[gi], mwm[gi]});
            end
            chk("idle_rsp", {srr, mrv[0], mrv[1]}, 64'b100);
            ev_acc = has_g && scr;
            ev_g   = gi;
        end else begin
            o = owner;
            chk("busy_cmd", {scv, mcr[0], mcr[1]}, 64'd0);
            if (mst == 1) begin
                chk("rsp_valid_owner", mrv[o], srv);
                chk("rsp_valid_other", mrv[~o], 1'b0);
                if (srv) chk("rsp_err_rdata", {mre[o], mrdat[o]}, {sre, srdat});
                chk("s_rsp_ready", srr, mrr[o]);
                ev_hs = srv && mrr[o];
            end else begin
                chk("err_rsp", {mrv[o], mre[o], mrv[~o]}, 64'b110);
                chk("err_rdata", mrdat[o], 64'd0);
                chk("err_s_rsp_ready", srr, 1'b0);
                ev_hs = mrr[o];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            mst      = 0;
            last_acc = 1'b1;
        end else begin
            case (mst)
                0: if (ev_acc) begin
                    last_acc = ev_g;
                    if (mrd[ev_g]) begin mst = 1; owner = ev_g; wcnt = 0; end
                end
                1: if (ev_hs) mst = 0;
                   else if (!srv) begin
                       wcnt++;
`ifdef SYSP_ARB_TIMEOUT_EN
                       if (wcnt == TO) mst = 2;
`endif
                   end
                default: if (ev_hs) mst = 0;
            endcase
        end
    endtask

    task automatic rnd_step();
        if (ev_hs) begin pend = 0; srv = 1'b0; end
        if (ev_acc && mrd[ev_g]) begin pend = 1; dly = $urandom_range(0, 3); end
        if (pend && !srv) begin
            if (dly == 0) begin
                srv   = 1'b1;
                sre   = 1'($urandom_range(0, 1));
                srdat = $urandom;
            end else dly--;
        end
        for (int i = 0; i < 2; i++) begin
            if (!(mv[i] && !(ev_acc && ev_g == 1'(i)))) begin
                mv[i]  = 1'($urandom_range(0, 1));
                mrd[i] = 1'($urandom_range(0, 1));
                ma[i]  = $urandom;
                mwd[i] = $urandom;
                mwm[i] = 4'($urandom);
            end
            mrr[i] = ($urandom_range(0, 3) != 0);
        end
        scr = ($urandom_range(0, 3) != 0);
    endtask

    logic e;

    initial begin
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mrd[i] = 0; mrr[i] = 1; ma[i] = '0; mwd[i] = '0; mwm[i] = '0;
        end
        scr = 0; srv = 0; sre = 0; srdat = '0;

        // Reset with inputs active: every output quiet.
        rst = 1; mv[0] = 1; mv[1] = 1; scr = 1; srv = 1;
        chk_now(); tick();
        chk_now(); tick();
        rst = 0; mv[0] = 0; mv[1] = 0; srv = 0;

        // Single m0 write passes straight through; priority then moves to m1.
        mv[0] = 1; mrd[0] = 0; ma[0] = 32'h0000_0104; mwd[0] = 32'hA5A5_0001; mwm[0] = 4'hF;
        chk_now();
        chk("t1_s_addr", sa, 32'h0000_0104);
        chk("t1_s_wdata", swd, 32'hA5A5_0001);
        chk("t1_m0_ready", mcr[0], 1'b1);
        tick();
        mv[1] = 1; mrd[1] = 0; ma[1] = 32'h0000_0200; mwd[0] = 32'hA5A5_0002;
        chk_now();
        chk("t1_prio_m1", {mcr[0], mcr[1]}, 64'b01);
        tick();
        mv[0] = 0; mv[1] = 0;

        // Simultaneous reads after reset: m0 first, then m1.
        rst = 1; chk_now(); tick(); rst = 0;
        mv[0] = 1; mrd[0] = 1; ma[0] = 32'h10; mv[1] = 1; mrd[1] = 1; ma[1] = 32'h20;
        chk_now();
        chk("t2_m0_first", {mcr[0], mcr[1]}, 64'b10);
        tick();
        mv[0] = 0; srv = 1; srdat = 32'h1234; sre = 0; mrr[0] = 1;
        chk_now();
        chk("t2_m0_rsp", {mrv[0], mrv[1], mrdat[0]}, {2'b10, 32'h1234});
        tick();
        srv = 0;
        chk_now();
        chk("t2_m1_next", mcr[1], 1'b1);
        tick();
        mv[1] = 0; srv = 1; srdat = 32'h5678; mrr[1] = 1;
        chk_now();
        chk("t2_m1_rsp", {mrv[0], mrv[1], mrdat[1]}, {2'b01, 32'h5678});
        tick();
        srv = 0;

        // Owner stalls its response for three cycles.
        mv[0] = 1; mrd[0] = 1; ma[0] = 32'h30;
        chk_now(); tick();
        mv[0] = 0; mv[1] = 1; mrd[1] = 0; mrr[0] = 0; srv = 1; srdat = 32'hCAFE;
        for (int k = 0; k < 3; k++) begin
            chk_now();
            chk("t3_hold", {mcr[0], mcr[1], mrv[0], srr, mrdat[0]}, {4'b0010, 32'hCAFE});
            tick();
        end
        mrr[0] = 1;
        chk_now(); tick();
        srv = 0;
        chk_now();
        chk("t3_release", mcr[1], 1'b1);
        tick();
        mv[1] = 0;

        // Continuous write streams from both masters alternate one per cycle.
        mv[0] = 1; mv[1] = 1; mrd[0] = 0; mrd[1] = 0;
        e = ~last_acc;
        for (int k = 0; k < 16; k++) begin
            ma[0] = 32'h400 + 32'(k); ma[1] = 32'h800 + 32'(k);
            chk_now();
            chk("t4_alternate", mcr[e], 1'b1);
            tick();
            e = ~e;
        end
        mv[0] = 0; mv[1] = 0;

        // Reset during an outstanding read; the late slave response is dropped.
        mv[0] = 1; mrd[0] = 1; ma[0] = 32'h50;
        chk_now(); tick();
        mv[0] = 0; rst = 1;
        chk_now(); tick();
        rst = 0; srv = 1; srdat = 32'hBAD;
        chk_now();
        chk("t5_drop", {mrv[0], mrv[1], srr}, 64'b001);
        tick();
        srv = 0; mv[1] = 1; mrd[1] = 1; ma[1] = 32'h60;
        chk_now();
        chk("t5_m1_grant", mcr[1], 1'b1);
        tick();
        mv[1] = 0; srv = 1; srdat = 32'h77; mrr[1] = 1;
        chk_now();
        chk("t5_m1_rsp", {mrv[1], mrdat[1]}, {1'b1, 32'h77});
        tick();
        srv = 0;

        // Slave never answers.
        mv[0] = 1; mrd[0] = 1; ma[0] = 32'h70;
        chk_now(); tick();
        mv[0] = 0; mrr[0] = 1;
        for (int k = 0; k < int'(TO); k++) begin
            chk_now();
            chk("t6_wait", mrv[0], 1'b0);
            tick();
        end
        chk_now();
`ifdef SYSP_ARB_TIMEOUT_EN
        chk("t6_timeout_err", {mrv[0], mre[0], mrdat[0]}, {2'b11, 32'h0});
        tick();
`else
        chk("t6_still_waiting", mrv[0], 1'b0);
        tick();
        srv = 1; srdat = 32'h99; sre = 0;
        chk_now();
        chk("t6_late_rsp", {mrv[0], mrdat[0]}, {1'b1, 32'h99});
        tick();
        srv = 0;
`endif

        // Randomized traffic.
        ev_acc = 0; ev_hs = 0; pend = 0;
        for (int k = 0; k < 600; k++) begin
            rnd_step();
            chk_now();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
